lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between an RV32I core and a
// single-port, synchronous-read data memory. Handles byte/half/word loads
// with sign/zero extension, word stores directly, and byte/half stores via
// read-modify-write. Rejected requests answer with an error response and
// never touch memory.
module lsu_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Request fields captured on accept
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [1:0]            r_lane;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic w_accept;
    logic w_misaligned;
    logic w_illegal;
    logic w_out_of_range;
    logic w_err;

    // Pick the addressed byte/half out of the fetched word and extend it.
    // funct3[2] selects zero extension (LBU/LHU).
    function automatic logic [DATA_WIDTH-1:0] load_extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [2:0]            f3,
        input logic [1:0]            lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic        s;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00: begin
                s = ~f3[2] & b[7];
                load_extract = {{24{s}}, b};
            end
            2'b01: begin
                s = ~f3[2] & h[15];
                load_extract = {{16{s}}, h};
            end
            default: load_extract = word;
        endcase
    endfunction

    // Insert the low byte/half of the store data into the fetched word at
    // the addressed lane; the other lanes keep their memory contents.
    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [DATA_WIDTH-1:0] word,
        input logic [DATA_WIDTH-1:0] wd,
        input logic [2:0]            f3,
        input logic [1:0]            lane
    );
        logic [DATA_WIDTH-1:0] res;
        res = word;
        if (f3[1:0] == 2'b00) begin
            res[{lane, 3'b000} +: 8] = wd[7:0];
        end else begin
            res[{lane[1], 4'b0000} +: 16] = wd[15:0];
        end
        store_merge = res;
    endfunction

    assign w_accept = req_valid_i & req_ready_o;

    assign w_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                          ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));

    assign w_illegal = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                       (req_funct3_i == 3'b111) || (req_funct3_i[2] && req_we_i);

    assign w_out_of_range = (req_addr_i[31:ADDR_WIDTH+2] != '0);

    assign w_err = w_misaligned | w_illegal | w_out_of_range;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: error -> RESP, SW -> WRITE, loads and SB/SH -> READ
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next = RESP;
                    end else if (req_we_i && (req_funct3_i[1:0] == 2'b10)) begin
                        w_next = WRITE;
                    end else begin
                        w_next = READ;
                    end
                end
            end
            READ:    w_next = WAIT;
            WAIT:    w_next = r_we ? WRITE : RESP;
            WRITE:   w_next = RESP;
            RESP:    w_next = rsp_ready_i ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // Word address is the only datapath register visible outside, so it is cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_waddr <= '0;
        end else if (w_accept) begin
            r_waddr <= req_addr_i[ADDR_WIDTH+1:2];
        end
    end

    // Capture request fields on accept; in WAIT either extract load data or merge store data
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_we     <= req_we_i;
            r_funct3 <= req_funct3_i;
            r_lane   <= req_addr_i[1:0];
            r_wdata  <= req_wdata_i;
            r_rdata  <= '0;
            r_err    <= w_err;
        end else if (r_state == WAIT) begin
            if (r_we) begin
                r_wdata <= store_merge(mem_rdata_i, r_wdata, r_funct3, r_lane);
            end else begin
                r_rdata <= load_extract(mem_rdata_i, r_funct3, r_lane);
            end
        end
    end

    // Outputs decoded from state; response and write data are forced to zero outside their states
    always_comb begin
        req_ready_o = (r_state == IDLE) && !rst_i;
        rsp_valid_o = (r_state == RESP);
        rsp_err_o   = (r_state == RESP) && r_err;
        rsp_rdata_o = (r_state == RESP) ? r_rdata : '0;
        mem_we_o    = (r_state == WRITE) && !rst_i;
        mem_wdata_o = (r_state == WRITE) ? r_wdata : '0;
        mem_addr_o  = r_waddr;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: behavioural memory, byte-level reference model,
// directed scenarios followed by randomized requests.
module tb_lsu_ctrl;

    localparam int AW    = 10;
    localparam int WORDS = 1 << AW;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // Bench-side memory and preload port
    logic [31:0]   mem [0:WORDS-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;
    int            we_cnt = 0;
    logic [AW-1:0] last_waddr;
    logic [31:0]   last_wdata;

    // Reference memory image
    logic [31:0]   exp_mem [0:WORDS-1];

    int checks   = 0;
    int failures = 0;

    lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory with write-pulse monitor
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            we_cnt     <= we_cnt + 1;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [31:0] a);
        logic [31:0] w;
        w = exp_mem[a[AW+1:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    // Architectural result of one request, computed from byte-level semantics
    function automatic void model_eval(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr,
                                       output logic err, output logic [31:0] rd,
                                       output int lat);
        int size;
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        if (size == 0 || (we && f3[2]) || addr >= 32'(4 * WORDS))
            err = 1'b1;
        else
            err = ((addr % size) != 0);
        rd = 32'h0;
        if (err) begin
            lat = 1;
        end else if (we) begin
            lat = (size == 4) ? 2 : 4;
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++)
                v = v | (32'(model_byte(addr + 32'(i))) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1])
                v = v | (32'hFFFF_FFFF << (8 * size));
            rd  = v;
            lat = 3;
        end
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd);
        int size;
        logic [31:0] a;
        int sh;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        for (int i = 0; i < size; i++) begin
            a  = addr + 32'(i);
            sh = 8 * int'(a[1:0]);
            exp_mem[a[AW+1:2]] = (exp_mem[a[AW+1:2]] & ~(32'hFF << sh)) |
                                 (((wd >> (8 * i)) & 32'hFF) << sh);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pre_we   = 1'b1;
        pre_addr = AW'(idx);
        pre_data = val;
        step();
        pre_we   = 1'b0;
        exp_mem[idx] = val;
    endtask

    // One complete transaction: accept, latency, response hold, return to idle, memory effect
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int hold,
                           input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
        int k;
        int we0;
        logic [AW-1:0] widx;
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        we0 = we_cnt;
        step();
        req_valid = 1'b0;
        req_wdata = $urandom;
        k = 1;
        while (!rsp_valid && k < 12) begin
            step();
            k++;
        end
        chk("rsp_latency", 32'(k), 32'(exp_lat));
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("ready_busy", {31'b0, req_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", {31'b0, rsp_err}, {31'b0, exp_err});
            chk("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("back_idle", {31'b0, req_ready}, 32'd1);
        chk("rsp_dropped", {31'b0, rsp_valid}, 32'd0);
        chk("we_pulses", 32'(we_cnt - we0), (we && !exp_err) ? 32'd1 : 32'd0);
        if (we && !exp_err) begin
            model_store(f3, addr, wd);
            widx = addr[AW+1:2];
            chk("wr_addr", 32'(last_waddr), 32'(widx));
            chk("mem_word", mem[widx], exp_mem[widx]);
        end
    endtask

    initial begin
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        int          we0;
        logic        r_we_t;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        logic [31:0] r_wd;
        logic [2:0]  f3_tab [0:11];

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        pre_we     = 1'b0;
        pre_addr   = '0;
        pre_data   = 32'h0;
        for (int i = 0; i < WORDS; i++) exp_mem[i] = 32'h0;

        // Reset state
        repeat (3) step();
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b0;
        step();
        chk("rel_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 16; i++)
            preload(i, (i == 1) ? 32'h8070_60F0 : $urandom);

        // Word and sub-word loads from the preloaded word
        we0 = we_cnt;
        run_req(1'b0, 3'b010, 32'h004, 32'h0, 0, 1'b0, 32'h8070_60F0, 3);
        chk("lw_no_we", 32'(we_cnt - we0), 32'd0);
        run_req(1'b0, 3'b000, 32'h004, 32'h0, 0, 1'b0, 32'hFFFF_FFF0, 3);
        run_req(1'b0, 3'b100, 32'h007, 32'h0, 0, 1'b0, 32'h0000_0080, 3);
        run_req(1'b0, 3'b001, 32'h006, 32'h0, 0, 1'b0, 32'hFFFF_8070, 3);

        // Byte store via read-modify-write, then read back
        run_req(1'b1, 3'b000, 32'h005, 32'h0000_00AA, 0, 1'b0, 32'h0, 4);
        chk("sb_word", mem[1], 32'h8070_AAF0);
        chk("sb_pulse_data", last_wdata, 32'h8070_AAF0);
        run_req(1'b0, 3'b010, 32'h004, 32'h0, 0, 1'b0, 32'h8070_AAF0, 3);

        // Rejected requests
        we0 = we_cnt;
        run_req(1'b0, 3'b001, 32'h003, 32'h0, 0, 1'b1, 32'h0, 1);
        run_req(1'b1, 3'b010, 32'h1000, 32'h1234_5678, 0, 1'b1, 32'h0, 1);
        run_req(1'b0, 3'b011, 32'h008, 32'h0, 0, 1'b1, 32'h0, 1);
        run_req(1'b1, 3'b100, 32'h008, 32'h0, 0, 1'b1, 32'h0, 1);
        chk("err_no_we", 32'(we_cnt - we0), 32'd0);

        // Reset while an SH sits in WAIT
        we0 = we_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h002;
        req_wdata  = 32'h0000_BEEF;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
        chk("mid_rst_we", {31'b0, mem_we}, 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
        repeat (3) step();
        chk("post_rst_valid2", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_no_we", 32'(we_cnt - we0), 32'd0);
        chk("mid_rst_word", mem[0], exp_mem[0]);

        // Response held for five cycles
        run_req(1'b0, 3'b010, 32'h004, 32'h0, 5, 1'b0, 32'h8070_AAF0, 3);

        // Randomized requests against the reference model
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000,
                   3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b010};
        for (int n = 0; n < 60; n++) begin
            r_we_t = 1'($urandom_range(0, 1));
            r_f3   = f3_tab[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0)
                r_addr = $urandom | 32'h0000_1000;
            else
                r_addr = 32'($urandom_range(0, 63));
            r_wd = $urandom;
            model_eval(r_we_t, r_f3, r_addr, e_err, e_rd, e_lat);
            run_req(r_we_t, r_f3, r_addr, r_wd, $urandom_range(0, 2), e_err, e_rd, e_lat);
        end

        for (int i = 0; i < 16; i++)
            chk("final_mem", mem[i], exp_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
